// File: rtl/aes_plaintext_tx_serializer.sv
// Buffers 128-bit plaintext blocks from the AES decrypt core and streams each one
// out as 16 bytes on a valid/ready interface toward the UART transmitter.
module aes_plaintext_tx_serializer #(
    parameter int FIFO_DEPTH = 4,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          blk_valid,
    input  logic [127:0]                  blk_data,
    output logic [7:0]                    tx_data,
    output logic                          tx_valid,
    input  logic                          tx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          busy,
    output logic                          overflow,
    input  logic                          overflow_clr
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   cnt_q;
    logic [3:0]      byte_cnt_q, byte_cnt_d;
    logic [127:0]    shift_q;
    logic            ovf_q;
    logic [127:0]    mem [FIFO_DEPTH];

    logic            full, wr_en, drop, hs, pop;

    function automatic logic [7:0] head_byte(input logic [127:0] s);
        return MSB_FIRST ? s[127:120] : s[7:0];
    endfunction

    function automatic logic [127:0] advance(input logic [127:0] s);
        return MSB_FIRST ? {s[119:0], 8'h00} : {8'h00, s[127:8]};
    endfunction

    // Block FIFO stage: fullness comes from the registered count, so a pop in
    // the same cycle never frees room for an incoming block.
    assign full  = (cnt_q == FULL_CNT);
    assign wr_en = blk_valid && !full;
    assign drop  = blk_valid && full;
    assign hs    = (state_q == SEND) && tx_ready;

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        pop        = 1'b0;
        case (state_q)
            IDLE: begin
                if (cnt_q != '0) begin
                    pop        = 1'b1;
                    byte_cnt_d = '0;
                    state_d    = SEND;
                end
            end
            SEND: begin
                if (tx_ready) begin
                    if (byte_cnt_q != 4'd15) begin
                        byte_cnt_d = byte_cnt_q + 4'd1;
                    end else if (cnt_q != '0) begin
                        pop        = 1'b1;
                        byte_cnt_d = '0;
                    end else begin
                        byte_cnt_d = '0;
                        state_d    = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            byte_cnt_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            if (wr_en) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)   rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({wr_en, pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
            if (drop)              ovf_q <= 1'b1;
            else if (overflow_clr) ovf_q <= 1'b0;
        end
    end

    // Serializer stage: storage and shifter carry no reset; the FSM gates them.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q] <= blk_data;
        if (pop)     shift_q <= mem[rd_ptr_q];
        else if (hs) shift_q <= advance(shift_q);
    end

    assign tx_valid   = (state_q == SEND);
    assign tx_data    = tx_valid ? head_byte(shift_q) : 8'h00;
    assign fifo_count = cnt_q;
    assign busy       = tx_valid || (cnt_q != '0);
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_aes_plaintext_tx_serializer.sv
// Directed bench for aes_plaintext_tx_serializer: expected bytes go into a
// scoreboard queue as blocks are driven and are popped on each handshake.
module tb_aes_plaintext_tx_serializer;

    logic         clk = 1'b0;
    logic         rst;
    logic         blk_valid;
    logic [127:0] blk_data;
    logic [7:0]   tx_data;
    logic         tx_valid;
    logic         tx_ready;
    logic [2:0]   fifo_count;
    logic         busy;
    logic         overflow;
    logic         overflow_clr;

    aes_plaintext_tx_serializer #(.FIFO_DEPTH(4), .MSB_FIRST(1'b1)) dut (
        .clk          (clk),
        .rst          (rst),
        .blk_valid    (blk_valid),
        .blk_data     (blk_data),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .fifo_count   (fifo_count),
        .busy         (busy),
        .overflow     (overflow),
        .overflow_clr (overflow_clr)
    );

    always #5 clk = ~clk;

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] q[$];
    int         hs       = 0;
    int         hs0      = 0;
    int         gaps     = 0;
    int         maxcnt   = 0;
    bit         track    = 1'b0;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic [127:0] t;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] pat(input int k);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = 8'((k * 16) ^ (i * 7 + 3));
        return r;
    endfunction

    task automatic push_block(input logic [127:0] b);
        for (int i = 0; i < 16; i++) q.push_back(b[127 - 8*i -: 8]);
    endtask

    task automatic send_blk(input logic [127:0] b, input bit kept);
        blk_valid = 1'b1;
        blk_data  = b;
        if (kept) push_block(b);
        tick();
        blk_valid = 1'b0;
    endtask

    task automatic wait_drain(input int limit);
        int n = 0;
        while (n < limit && (q.size() != 0 || busy || tx_valid)) begin
            tick();
            n++;
        end
        chk("drain_queue", 128'(q.size()), 128'd0);
        chk("drain_busy", 128'(busy), 128'd0);
    endtask

    // Monitor: handshake happens at the next rising edge when seen here.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", 128'(tx_valid), 128'd1);
                chk("hold_data", 128'(tx_data), 128'(prev_data));
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
            if (tx_ready && q.size() == 0) begin
                chk("spurious_valid", 128'(tx_valid), 128'd0);
            end else if (tx_valid && tx_ready) begin
                hs++;
                chk("byte", 128'(tx_data), 128'(q.pop_front()));
            end
            if (!tx_valid && q.size() != 0) gaps++;
            if (track && int'(fifo_count) > maxcnt) maxcnt = int'(fifo_count);
        end
    end

    initial begin
        rst          = 1'b1;
        blk_valid    = 1'b0;
        blk_data     = '0;
        tx_ready     = 1'b0;
        overflow_clr = 1'b0;
        tick();
        tick();
        chk("rst_tx_valid", 128'(tx_valid), 128'd0);
        chk("rst_tx_data", 128'(tx_data), 128'd0);
        chk("rst_fifo_count", 128'(fifo_count), 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_overflow", 128'(overflow), 128'd0);
        rst      = 1'b0;
        tx_ready = 1'b1;
        tick();

        // Single block, latency and ordering
        send_blk(128'h00112233_44556677_8899AABB_CCDDEEFF, 1'b1);
        @(negedge clk);
        chk("lat_not_yet", 128'(tx_valid), 128'd0);
        chk("lat_busy", 128'(busy), 128'd1);
        @(negedge clk);
        chk("lat_valid", 128'(tx_valid), 128'd1);
        chk("lat_byte0", 128'(tx_data), 128'h00);
        gaps = 0;
        wait_drain(40);
        chk("single_gaps", 128'(gaps), 128'd0);
        chk("single_idle", 128'(tx_valid), 128'd0);

        // Backpressure with tx_ready pattern 1,0,0
        hs0 = hs;
        send_blk(128'h00112233_44556677_8899AABB_CCDDEEFF, 1'b1);
        for (int i = 0; i < 300 && (q.size() != 0 || busy); i++) begin
            tx_ready = (i % 3 == 0);
            tick();
        end
        tx_ready = 1'b1;
        wait_drain(40);
        chk("bp_handshakes", 128'(hs - hs0), 128'd16);

        // Burst of four back-to-back blocks
        hs0    = hs;
        maxcnt = 0;
        track  = 1'b1;
        for (int k = 0; k < 4; k++) send_blk(pat(k), 1'b1);
        gaps = 0;
        wait_drain(100);
        track = 1'b0;
        chk("burst_peak", 128'(maxcnt), 128'd3);
        chk("burst_gaps", 128'(gaps), 128'd0);
        chk("burst_handshakes", 128'(hs - hs0), 128'd64);
        chk("burst_overflow", 128'(overflow), 128'd0);

        // Overflow: six blocks while stalled, sixth dropped
        tx_ready = 1'b0;
        for (int k = 0; k < 6; k++) send_blk(pat(10 + k), k < 5);
        t = pat(10);
        chk("ovf_set", 128'(overflow), 128'd1);
        chk("ovf_count", 128'(fifo_count), 128'd4);
        chk("ovf_valid", 128'(tx_valid), 128'd1);
        chk("ovf_head", 128'(tx_data), 128'(t[127:120]));
        overflow_clr = 1'b1;
        send_blk(pat(16), 1'b0);
        overflow_clr = 1'b0;
        chk("ovf_set_wins", 128'(overflow), 128'd1);
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;
        chk("ovf_cleared", 128'(overflow), 128'd0);
        chk("ovf_count_hold", 128'(fifo_count), 128'd4);

        // Full FIFO with a pop on the same edge as an incoming block
        tx_ready = 1'b1;
        repeat (15) tick();
        chk("fullpop_pre_count", 128'(fifo_count), 128'd4);
        send_blk(pat(17), 1'b0);
        t = pat(11);
        chk("fullpop_overflow", 128'(overflow), 128'd1);
        chk("fullpop_count", 128'(fifo_count), 128'd3);
        chk("fullpop_no_bubble", 128'(tx_valid), 128'd1);
        chk("fullpop_next_head", 128'(tx_data), 128'(t[127:120]));
        wait_drain(200);
        chk("fullpop_sticky", 128'(overflow), 128'd1);

        // Reset mid-block with two blocks queued
        hs0 = hs;
        send_blk(pat(20), 1'b1);
        send_blk(pat(21), 1'b1);
        send_blk(pat(22), 1'b1);
        repeat (5) tick();
        chk("prerst_bytes", 128'(hs - hs0), 128'd6);
        chk("prerst_count", 128'(fifo_count), 128'd2);
        rst = 1'b1;
        q.delete();
        tick();
        chk("midrst_tx_valid", 128'(tx_valid), 128'd0);
        chk("midrst_fifo_count", 128'(fifo_count), 128'd0);
        chk("midrst_overflow", 128'(overflow), 128'd0);
        chk("midrst_busy", 128'(busy), 128'd0);
        chk("midrst_tx_data", 128'(tx_data), 128'd0);
        rst = 1'b0;
        hs0 = hs;
        repeat (30) tick();
        chk("postrst_silent", 128'(hs - hs0), 128'd0);
        chk("postrst_valid", 128'(tx_valid), 128'd0);

        // Recovery after reset
        send_blk(pat(23), 1'b1);
        wait_drain(40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
